// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per
//   clock, LSB first, through a single full-subtractor cell with a registered
//   borrow. A start/done handshake lets a controller issue one operation at a
//   time; the result and final borrow are held until the next completion.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      request, sampled only while idle
//   a          in   WIDTH  minuend, captured when start is accepted
//   b          in   WIDTH  subtrahend, captured when start is accepted
//   busy       out  1      high while bits are being processed
//   done       out  1      one-cycle pulse, result valid
//   diff       out  WIDTH  (a - b) mod 2^WIDTH, held until next completion
//   borrow_out out  1      final borrow (a < b), held with diff
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Full-subtractor cell; returns {borrow_next, diff_bit}.
  function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic br);
    logic d;
    logic bo;
    d  = ai ^ bi ^ br;
    bo = (~ai & bi) | (~(ai ^ bi) & br);
    return {bo, d};
  endfunction

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] d_sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic [1:0]       fs_d;
  logic [WIDTH-1:0] d_sr_d;
  logic             last_bit_d;

  // Current bit slice: difference bit, next borrow and the shifted result word.
  always_comb begin
    fs_d       = full_sub(a_sr_q[0], b_sr_q[0], br_q);
    d_sr_d     = {fs_d[0], d_sr_q[WIDTH-1:1]};
    last_bit_d = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Control FSM, bit-serial datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
          d_sr_q <= d_sr_d;
          br_q   <= fs_d[1];
          cnt_q  <= cnt_q + CNT_W'(1);
          // Outputs are only updated here so partial results never leak out.
          if (last_bit_d) begin
            diff_q   <= d_sr_d;
            borrow_q <= fs_d[1];
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance: directed tests + random
  logic       rst_n, start8, busy8, done8, bor8;
  logic [7:0] a8, b8, diff8;
  // 13-bit instance: random run in parallel
  logic        rst13_n, start13, busy13, done13, bor13;
  logic [12:0] a13, b13, diff13;

  int total = 0;
  int bad   = 0;

  logic [8:0]  q8[$];
  logic [13:0] q13[$];
  logic [8:0]  prev8;
  logic [13:0] prev13;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bor8)
  );

  serial_subtractor #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst_n(rst13_n), .start(start13), .a(a13), .b(b13),
    .busy(busy13), .done(done13), .diff(diff13), .borrow_out(bor13)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d;
    d = x - y;
    q8.push_back({(x < y), d});
  endfunction

  function automatic void push13(input logic [12:0] x, input logic [12:0] y);
    logic [12:0] d;
    d = x - y;
    q13.push_back({(x < y), d});
  endfunction

  // Scoreboard and hold-stability monitor, 8-bit instance
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      prev8 = 9'd0;
    end else if (done8) begin
      if (q8.size() == 0) begin
        chk("spurious_done8", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        chk("diff8", 32'(diff8), 32'(e[7:0]));
        chk("borrow8", 32'(bor8), 32'(e[8]));
      end
      prev8 = {bor8, diff8};
    end else begin
      chk("hold8", 32'({bor8, diff8}), 32'(prev8));
      prev8 = {bor8, diff8};
    end
  end

  // Scoreboard and hold-stability monitor, 13-bit instance
  always @(negedge clk) begin
    logic [13:0] e;
    if (!rst13_n) begin
      prev13 = 14'd0;
    end else if (done13) begin
      if (q13.size() == 0) begin
        chk("spurious_done13", 32'd1, 32'd0);
      end else begin
        e = q13.pop_front();
        chk("diff13", 32'(diff13), 32'(e[12:0]));
        chk("borrow13", 32'(bor13), 32'(e[13]));
      end
      prev13 = {bor13, diff13};
    end else begin
      chk("hold13", 32'({bor13, diff13}), 32'(prev13));
      prev13 = {bor13, diff13};
    end
  end

  // Observe the 10 cycles after an accept edge; ends on the negedge before E10.
  task automatic watch8(output int bcnt, output int dk);
    bcnt = 0;
    dk   = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy8) bcnt++;
      if (done8) dk = (dk < 0) ? k : 100;
    end
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y);
    int bc, dk;
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    push8(x, y);
    @(posedge clk);
    #1 start8 = 1'b0;
    watch8(bc, dk);
    chk("busy_cycles8", 32'(bc), 32'd8);
    chk("done_edge8", 32'(dk), 32'd8);
  endtask

  task automatic directed8();
    int bc, dk, dones;
    op8(8'h5A, 8'h3C);
    op8(8'h00, 8'h01);
    op8(8'hA5, 8'hA5);
    op8(8'hFF, 8'h00);

    // start pulses during SHIFT and DONE must be ignored
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    push8(8'h80, 8'h01);
    @(posedge clk);
    #1 start8 = 1'b0;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8) dones++;
      if (k == 3) begin
        a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
      end else if (k == 8) begin
        start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
    end
    chk("ignored_dones", 32'(dones), 32'd1);
    chk("after_ignore", 32'({bor8, diff8}), 32'h0000_007F);

    // start held high: one accept every 10 cycles
    @(negedge clk);
    a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
    push8(a8, b8);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      watch8(bc, dk);
      chk("hold_busy8", 32'(bc), 32'd8);
      chk("hold_done8", 32'(dk), 32'd8);
      if (i < 4) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        push8(a8, b8);
        @(posedge clk);
      end else begin
        start8 = 1'b0;
      end
    end

    // asynchronous reset mid-SHIFT
    op8(8'h5A, 8'h3C);
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_diff8", 32'(diff8), 32'd0);
    chk("rst_borrow8", 32'(bor8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op8(8'h10, 8'h20);
    chk("post_rst_result", 32'({bor8, diff8}), 32'h0000_01F0);
  endtask

  task automatic rand8();
    bit seen;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
      push8(a8, b8);
      @(posedge clk);
      #1 start8 = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (done8) seen = 1'b1;
      end
      chk("rand8_done", 32'(seen), 32'd1);
    end
  endtask

  task automatic rand13();
    bit seen;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a13 = 13'($urandom); b13 = 13'($urandom); start13 = 1'b1;
      push13(a13, b13);
      @(posedge clk);
      #1 start13 = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
        @(negedge clk);
        if (done13) seen = 1'b1;
      end
      chk("rand13_done", 32'(seen), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    rst13_n = 1'b0; start13 = 1'b0; a13 = 13'd0; b13 = 13'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_done8", 32'(done8), 32'd0);
    chk("reset_diff8", 32'(diff8), 32'd0);
    chk("reset_borrow8", 32'(bor8), 32'd0);
    chk("reset_busy13", 32'(busy13), 32'd0);
    chk("reset_diff13", 32'(diff13), 32'd0);
    rst_n = 1'b1;
    rst13_n = 1'b1;
    fork
      begin
        directed8();
        rand8();
      end
      rand13();
    join
    repeat (12) @(negedge clk);
    chk("q8_empty", 32'(q8.size()), 32'd0);
    chk("q13_empty", 32'(q13.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
